// File: rtl/nor4_selftest_ctrl.sv
// nor4_selftest_ctrl: exhaustive self-test sequencer/checker
// for the 4-input NOR datapath (oute, outf, outg).
module nor4_selftest_ctrl #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  output logic       ina,
  output logic       inb,
  output logic       inc,
  output logic       ind,
  input  logic       oute,
  input  logic       outf,
  input  logic       outg,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [4:0] err_cnt,
  output logic       fail_valid,
  output logic [3:0] fail_vec
);

  typedef enum logic [1:0] {
    IDLE,
    APPLY,
    CHECK,
    DONE
  } state_t;

  localparam logic [3:0] LAST = 4'(SETTLE_CYCLES - 1);

  state_t     state, state_n;
  logic [3:0] vec, vec_n;
  logic [3:0] cnt, cnt_n;
  logic [4:0] err_n;
  logic       fv_n;
  logic [3:0] fvec_n;
  logic       exp_e, exp_f, exp_g;
  logic       mism;

  assign ina = vec[3];
  assign inb = vec[2];
  assign inc = vec[1];
  assign ind = vec[0];

  assign busy = (state == APPLY) || (state == CHECK);
  assign done = (state == DONE);
  assign pass = done && (err_cnt == 5'd0);

  assign exp_e = ~(vec[3] | vec[2]);
  assign exp_f = ~(vec[1] | vec[0]);
  assign exp_g = ~(|vec);
  assign mism  = (oute != exp_e) ||
                 (outf != exp_f) ||
                 (outg != exp_g);

  // State, vector, settle counter and result registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      vec        <= 4'd0;
      cnt        <= 4'd0;
      err_cnt    <= 5'd0;
      fail_valid <= 1'b0;
      fail_vec   <= 4'd0;
    end else begin
      state      <= state_n;
      vec        <= vec_n;
      cnt        <= cnt_n;
      err_cnt    <= err_n;
      fail_valid <= fv_n;
      fail_vec   <= fvec_n;
    end
  end

  // Sequencing: settle each vector, check it, step or finish
  always_comb begin
    state_n = state;
    vec_n   = vec;
    cnt_n   = cnt;
    err_n   = err_cnt;
    fv_n    = fail_valid;
    fvec_n  = fail_vec;
    unique case (state)
      IDLE, DONE: begin
        if (start) begin
          state_n = APPLY;
          vec_n   = 4'd0;
          cnt_n   = 4'd0;
          err_n   = 5'd0;
          fv_n    = 1'b0;
          fvec_n  = 4'd0;
        end
      end
      APPLY: begin
        cnt_n = cnt + 4'd1;
        if (abort) begin
          state_n = IDLE;
          vec_n   = 4'd0;
          cnt_n   = 4'd0;
        end else if (cnt == LAST) begin
          state_n = CHECK;
        end
      end
      CHECK: begin
        cnt_n = 4'd0;
        if (abort) begin
          state_n = IDLE;
          vec_n   = 4'd0;
        end else begin
          if (mism) begin
            err_n = err_cnt + 5'd1;
            if (!fail_valid) begin
              fv_n   = 1'b1;
              fvec_n = vec;
            end
          end
          if (vec == 4'd15) begin
            state_n = DONE;
            vec_n   = 4'd0;
          end else begin
            state_n = APPLY;
            vec_n   = vec + 4'd1;
          end
        end
      end
    endcase
  end

endmodule

// File: tb/tb_nor4_selftest_ctrl.sv
// tb_nor4_selftest_ctrl: directed bench for the NOR self-test
// controller, with fault-injectable NOR datapath models.
module tb_nor4_selftest_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0, abort = 1'b0;
  logic ina, inb, inc, ind;
  logic oute, outf, outg;
  logic busy, done, pass, fail_valid;
  logic [4:0] err_cnt;
  logic [3:0] fail_vec;
  logic flt_f = 1'b0, flt_g = 1'b0;

  logic start2 = 1'b0, abort2 = 1'b0;
  logic ina2, inb2, inc2, ind2;
  logic oute2, outf2, outg2;
  logic busy2, done2, pass2, fail_valid2;
  logic [4:0] err_cnt2;
  logic [3:0] fail_vec2;
  logic flt2_g = 1'b0;

  int tests = 0;
  int fails = 0;
  int n;

  always #5 clk = ~clk;

  assign oute = ~(ina | inb);
  assign outf = flt_f ? 1'b1 : ~(inc | ind);
  assign outg = flt_g ? 1'b0 : ~(ina | inb | inc | ind);

  assign oute2 = ~(ina2 | inb2);
  assign outf2 = ~(inc2 | ind2);
  assign outg2 = flt2_g ? 1'b0 : ~(ina2 | inb2 | inc2 | ind2);

  nor4_selftest_ctrl #(.SETTLE_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .ina(ina), .inb(inb), .inc(inc), .ind(ind),
    .oute(oute), .outf(outf), .outg(outg),
    .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
    .fail_valid(fail_valid), .fail_vec(fail_vec)
  );

  nor4_selftest_ctrl #(.SETTLE_CYCLES(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .abort(abort2),
    .ina(ina2), .inb(inb2), .inc(inc2), .ind(ind2),
    .oute(oute2), .outf(outf2), .outg(outg2),
    .busy(busy2), .done(done2), .pass(pass2), .err_cnt(err_cnt2),
    .fail_valid(fail_valid2), .fail_vec(fail_vec2)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // called at #1 after the start edge; returns edges until done
  task automatic wait_done1(input bit chkvec, output int cyc);
    cyc = 0;
    chk("start_busy", busy, 1);
    chk("start_done_low", done, 0);
    while (!done && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      if (chkvec && cyc < 48 && (cyc % 3) == 0)
        chk("vec_step", {ina, inb, inc, ind}, cyc / 3);
    end
  endtask

  task automatic wait_done2(output int cyc);
    cyc = 0;
    while (!done2 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic pulse_start1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  initial begin
    // reset
    repeat (2) @(posedge clk);
    #1;
    chk("rst_vec", {ina, inb, inc, ind}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_err", err_cnt, 0);
    chk("rst_fv", fail_valid, 0);
    chk("rst_fvec", fail_vec, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // clean run
    pulse_start1();
    wait_done1(1'b1, n);
    chk("clean_latency", n, 48);
    chk("clean_pass", pass, 1);
    chk("clean_err", err_cnt, 0);
    chk("clean_fv", fail_valid, 0);
    chk("clean_busy", busy, 0);

    // outg stuck-at-0, started from DONE
    flt_g = 1'b1;
    pulse_start1();
    wait_done1(1'b0, n);
    chk("g0_latency", n, 48);
    chk("g0_err", err_cnt, 1);
    chk("g0_fv", fail_valid, 1);
    chk("g0_fvec", fail_vec, 0);
    chk("g0_pass", pass, 0);
    flt_g = 1'b0;

    // outf stuck-at-1
    flt_f = 1'b1;
    pulse_start1();
    wait_done1(1'b0, n);
    chk("f1_err", err_cnt, 12);
    chk("f1_fvec", fail_vec, 1);
    chk("f1_pass", pass, 0);
    flt_f = 1'b0;

    // start+abort together in DONE: start wins
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    abort = 1'b0;
    chk("sa_done_busy", busy, 1);
    chk("sa_done_err_clr", err_cnt, 0);
    repeat (15) @(posedge clk);
    #1;
    chk("abort_at_vec5", {ina, inb, inc, ind}, 5);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_vec", {ina, inb, inc, ind}, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("abort_idle_hold", busy, 0);

    // clean run after abort
    pulse_start1();
    wait_done1(1'b0, n);
    chk("post_abort_latency", n, 48);
    chk("post_abort_pass", pass, 1);

    // start while busy ignored, then reset mid-run
    flt_f = 1'b1;
    pulse_start1();
    repeat (10) @(posedge clk);
    #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_start_vec", {ina, inb, inc, ind}, 3);
    @(posedge clk); #1;
    chk("busy_start_ignored", {ina, inb, inc, ind}, 4);
    chk("partial_err", err_cnt, 3);
    chk("partial_fvec", fail_vec, 1);
    rst_n = 1'b0;
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    flt_f = 1'b0;
    chk("mrst_busy", busy, 0);
    chk("mrst_vec", {ina, inb, inc, ind}, 0);
    chk("mrst_err", err_cnt, 0);
    chk("mrst_fv", fail_valid, 0);
    chk("mrst_fvec", fail_vec, 0);
    repeat (5) @(posedge clk);
    #1;
    chk("mrst_no_done", done, 0);
    chk("mrst_no_pass", pass, 0);

    // SETTLE_CYCLES=1 instance
    flt2_g = 1'b1;
    start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    wait_done2(n);
    chk("s1_fault_latency", n, 32);
    chk("s1_fault_err", err_cnt2, 1);
    chk("s1_fault_pass", pass2, 0);
    flt2_g = 1'b0;
    start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    chk("s1_restart_done", done2, 0);
    chk("s1_restart_err", err_cnt2, 0);
    chk("s1_restart_fv", fail_valid2, 0);
    chk("s1_restart_busy", busy2, 1);
    wait_done2(n);
    chk("s1_latency", n, 32);
    chk("s1_pass", pass2, 1);
    chk("s1_fvec", fail_vec2, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
